bus_master_ctrl: RTL and testbench
==================================

Name: bus_master_ctrl

Overview:
- Per-master bus sequencer that sits between a core-side load/store port and the shared system bus.
- Requests ownership from the four-master bus arbiter and waits for grant.
- Issues one address-strobe access, waits for slave ready (with watchdog timeout), returns read data or an error, then releases the bus.
- One instance per bus master (m0..m3).

Parameters:
- ADDR_W, 30, bus word-address width.
- DATA_W, 32, bus data width.
- TIMEOUT, 255, maximum WAIT cycles before abort; legal range 1..255.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- core_req  in  1  access request, level, active-high.
- core_rw  in  1  1 = read, 0 = write.
- core_addr  in  ADDR_W  access address.
- core_wr_data  in  DATA_W  write data.
- core_rd_data  out  DATA_W  read data, valid while core_ack=1.
- core_ack  out  1  one-cycle completion pulse.
- core_err  out  1  timeout/abort flag, valid with core_ack.
- core_busy  out  1  transaction in progress.
- bus_req_  out  1  request to arbiter, active-low.
- bus_grnt_  in  1  grant from arbiter, active-low.
- bus_as_  out  1  address strobe, active-low.
- bus_rw  out  1  1 = read, 0 = write.
- bus_addr  out  ADDR_W  bus address.
- bus_wr_data  out  DATA_W  bus write data.
- bus_rd_data  in  DATA_W  slave read data.
- bus_rdy_  in  1  slave ready, active-low.

Behaviour:
- All outputs registered. Reset values: bus_req_=1, bus_as_=1, bus_rw=1, bus_addr=0, bus_wr_data=0, core_rd_data=0, core_ack=0, core_err=0, core_busy=0, state=IDLE.
- States: IDLE, REQ, ACCESS, WAIT, DONE.
- IDLE:
  - When core_req=1, latch rw/addr/wr_data, set bus_req_=0 and core_busy=1, go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - Hold bus_req_=0.
  - When bus_grnt_=0, go to ACCESS: drive bus_as_=0, bus_rw, bus_addr, bus_wr_data; clear the watchdog.
  - No timeout applies while in REQ.
- ACCESS: one cycle only, then WAIT with bus_as_=1. Address, rw and data stay stable through WAIT.
- WAIT:
  - Sample bus_rdy_ each cycle.
  - bus_rdy_=0: capture bus_rd_data (read) or 0 (write) into core_rd_data; go to DONE with err=0.
  - Otherwise increment the watchdog. When the count reaches TIMEOUT-1 with no ready, go to DONE with err=1 and core_rd_data=0.
  - Ready and timeout in the same cycle: ready wins.
- Grant loss: bus_grnt_=1 in ACCESS or WAIT aborts to DONE with err=1.
- DONE:
  - core_ack=1 for exactly one cycle, core_err as determined.
  - bus_req_=1; bus_addr/bus_wr_data return to 0 and bus_rw to 1. Zero-drive while not owner is required because the bus is OR-combined.
  - Go to IDLE; core_busy=0 from IDLE.
- Back-to-back: core_req still high in DONE is ignored; it is accepted in the following IDLE cycle.
- Latency: core_req sampled at cycle N; REQ at N+1; with grant already present, ACCESS at N+2; WAIT at N+3; ready at N+3 gives ack at N+4. Minimum latency is 4 cycles.
- Core inputs are ignored outside IDLE.
- Reset asserted mid-transaction: immediately return to IDLE with reset values. bus_as_/bus_req_ deassert asynchronously, no ack is produced, and the transaction is lost.

Decomposition:
- Shared bus package (extends the existing bus header) holds:
  - BUS_READ=1 and BUS_WRITE=0;
  - the state encoding (3-bit);
  - the watchdog width (8).
- One natural sub-module: bus_watchdog. It is an 8-bit clear/increment counter with a terminal-count output compared against TIMEOUT-1.

Test Plan:
- Read, grant already low, slave ready on first WAIT cycle, bus_rd_data=0xDEADBEEF → bus_as_ low for one cycle at N+2; core_ack at N+4 with core_rd_data=0xDEADBEEF, core_err=0.
- Write to addr 0x100 with data 0x12345678, grant delayed 3 cycles → bus_req_ low from N+1; bus_as_ asserted the cycle after grant with bus_addr=0x100 and bus_wr_data=0x12345678; ack with core_rd_data=0.
- Read with TIMEOUT=4, bus_rdy_ never asserted → exactly 4 WAIT cycles, then core_ack=1, core_err=1, core_rd_data=0; bus_req_ high and bus_addr=0 in DONE.
- Ready arrives on the timeout cycle (WAIT cycle 4, TIMEOUT=4) → core_err=0 and data captured.
- Reset pulsed during WAIT → all outputs at reset values in the same cycle, no core_ack; a new request after reset completes normally.
- core_req held high continuously → transactions separated by one IDLE cycle; two acks for two accesses; bus_req_ deasserted for at least DONE+IDLE between them.

Source files
------------

// File: rtl/bus_master_ctrl_pkg.sv
// Shared bus definitions for the per-master sequencer:
// transfer direction, sequencer state encoding and watchdog sizing.
package bus_master_ctrl_pkg;

  localparam logic BUS_READ  = 1'b1;
  localparam logic BUS_WRITE = 1'b0;

  localparam int WD_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_ACCESS = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  function automatic logic [WD_W-1:0] wd_tc(
    input int unsigned timeout
  );
    return WD_W'(timeout - 1);
  endfunction

endpackage

// File: rtl/bus_master_ctrl_if.sv
// Core load/store port plus shared system bus signals for one master.
// master = sequencer side, slave = core/arbiter/bus side.
interface bus_master_ctrl_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);

  logic              core_req;
  logic              core_rw;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wr_data;
  logic [DATA_W-1:0] core_rd_data;
  logic              core_ack;
  logic              core_err;
  logic              core_busy;

  logic              bus_req_;
  logic              bus_grnt_;
  logic              bus_as_;
  logic              bus_rw;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wr_data;
  logic [DATA_W-1:0] bus_rd_data;
  logic              bus_rdy_;

  modport master (
    input  core_req, core_rw, core_addr,
    input  core_wr_data,
    output core_rd_data, core_ack,
    output core_err, core_busy,
    output bus_req_, bus_as_, bus_rw,
    output bus_addr, bus_wr_data,
    input  bus_grnt_, bus_rd_data, bus_rdy_
  );

  modport slave (
    output core_req, core_rw, core_addr,
    output core_wr_data,
    input  core_rd_data, core_ack,
    input  core_err, core_busy,
    input  bus_req_, bus_as_, bus_rw,
    input  bus_addr, bus_wr_data,
    output bus_grnt_, bus_rd_data, bus_rdy_
  );

endinterface

// File: rtl/bus_master_ctrl_watchdog.sv
// bus_watchdog: clear/increment wait counter with a
// terminal-count flag at TIMEOUT-1.
module bus_watchdog
  import bus_master_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  logic [WD_W-1:0] cnt_q;
  logic [WD_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i)
      cnt_d = cnt_q + WD_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == wd_tc(TIMEOUT));

endmodule

// File: rtl/bus_master_ctrl.sv
// Per-master bus sequencer: arbitrate, strobe one access,
// wait for ready or watchdog, report to the core, release.
module bus_master_ctrl
  import bus_master_ctrl_pkg::*;
#(
  parameter int          ADDR_W  = 30,
  parameter int          DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input logic         clk,
  input logic         reset,
  bus_master_ctrl_if.master bus
);

  state_e state_q, state_d;

  logic              lrw_q, lrw_d;
  logic [ADDR_W-1:0] laddr_q, laddr_d;
  logic [DATA_W-1:0] lwdat_q, lwdat_d;

  logic              req_q, req_d;
  logic              as_q, as_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;
  logic [DATA_W-1:0] rdat_q, rdat_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  logic              wd_clr;
  logic              wd_inc;
  logic              wd_tc;
  logic              fin;
  logic              fin_err;
  logic [DATA_W-1:0] fin_dat;

  bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .clk   (clk),
    .reset (reset),
    .clr_i (wd_clr),
    .inc_i (wd_inc),
    .tc_o  (wd_tc)
  );

  always_comb begin
    state_d = state_q;
    lrw_d   = lrw_q;
    laddr_d = laddr_q;
    lwdat_d = lwdat_q;
    req_d   = req_q;
    as_d    = as_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    ack_d   = 1'b0;
    err_d   = err_q;
    busy_d  = busy_q;
    wd_clr  = 1'b0;
    wd_inc  = 1'b0;
    fin     = 1'b0;
    fin_err = 1'b0;
    fin_dat = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.core_req) begin
          lrw_d   = bus.core_rw;
          laddr_d = bus.core_addr;
          lwdat_d = bus.core_wr_data;
          req_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (!bus.bus_grnt_) begin
          as_d    = 1'b0;
          rw_d    = lrw_q;
          addr_d  = laddr_q;
          wdat_d  = lwdat_q;
          wd_clr  = 1'b1;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (bus.bus_grnt_) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else begin
          as_d    = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // ready beats both grant loss and watchdog expiry
        if (!bus.bus_rdy_) begin
          fin = 1'b1;
          if (lrw_q == BUS_READ)
            fin_dat = bus.bus_rd_data;
        end else if (bus.bus_grnt_ || wd_tc) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else begin
          wd_inc = 1'b1;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // bus is OR-combined: release everything to zero
    if (fin) begin
      state_d = ST_DONE;
      ack_d   = 1'b1;
      err_d   = fin_err;
      rdat_d  = fin_dat;
      req_d   = 1'b1;
      as_d    = 1'b1;
      rw_d    = BUS_READ;
      addr_d  = '0;
      wdat_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      lrw_q   <= BUS_READ;
      laddr_q <= '0;
      lwdat_q <= '0;
      req_q   <= 1'b1;
      as_q    <= 1'b1;
      rw_q    <= BUS_READ;
      addr_q  <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lrw_q   <= lrw_d;
      laddr_q <= laddr_d;
      lwdat_q <= lwdat_d;
      req_q   <= req_d;
      as_q    <= as_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.bus_req_     = req_q;
  assign bus.bus_as_      = as_q;
  assign bus.bus_rw       = rw_q;
  assign bus.bus_addr     = addr_q;
  assign bus.bus_wr_data  = wdat_q;
  assign bus.core_rd_data = rdat_q;
  assign bus.core_ack     = ack_q;
  assign bus.core_err     = err_q;
  assign bus.core_busy    = busy_q;

endmodule

// File: tb/tb_bus_master_ctrl.sv
// Directed bench for bus_master_ctrl with TIMEOUT=4.
module tb_bus_master_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   acks;

  bus_master_ctrl_if #(
    .ADDR_W (30),
    .DATA_W (32)
  ) bif ();

  bus_master_ctrl #(
    .ADDR_W  (30),
    .DATA_W  (32),
    .TIMEOUT (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1);
  end

  task automatic cyc();
    @(negedge clk);
    if (bif.core_ack === 1'b1)
      acks++;
  endtask

  task automatic chkb(input string tag,
                      input logic obs,
                      input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b",
             tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_rst_vals(input string tag);
    chkb({tag, "_req"},  bif.bus_req_, 1'b1);
    chkb({tag, "_as"},   bif.bus_as_, 1'b1);
    chkb({tag, "_rw"},   bif.bus_rw, 1'b1);
    chkd({tag, "_addr"}, 32'(bif.bus_addr), 32'h0);
    chkd({tag, "_wd"},   bif.bus_wr_data, 32'h0);
    chkd({tag, "_rd"},   bif.core_rd_data, 32'h0);
    chkb({tag, "_ack"},  bif.core_ack, 1'b0);
    chkb({tag, "_err"},  bif.core_err, 1'b0);
    chkb({tag, "_busy"}, bif.core_busy, 1'b0);
  endtask

  task automatic issue(input logic rw,
                       input logic [29:0] a,
                       input logic [31:0] wd);
    bif.core_req     = 1'b1;
    bif.core_rw      = rw;
    bif.core_addr    = a;
    bif.core_wr_data = wd;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    acks     = 0;
    reset    = 1'b1;
    bif.core_req     = 1'b0;
    bif.core_rw      = 1'b1;
    bif.core_addr    = '0;
    bif.core_wr_data = '0;
    bif.bus_grnt_    = 1'b1;
    bif.bus_rd_data  = '0;
    bif.bus_rdy_     = 1'b1;

    repeat (2) cyc();
    chk_rst_vals("rst");
    reset = 1'b0;
    cyc();

    // read, grant present, ready on first WAIT
    bif.bus_grnt_   = 1'b0;
    bif.bus_rd_data = 32'hDEADBEEF;
    issue(1'b1, 30'h55, 32'h0);
    cyc();
    bif.core_req = 1'b0;
    chkb("rd_busy", bif.core_busy, 1'b1);
    chkb("rd_req",  bif.bus_req_, 1'b0);
    chkb("rd_as_n1", bif.bus_as_, 1'b1);
    cyc();
    chkb("rd_as_n2", bif.bus_as_, 1'b0);
    chkd("rd_addr", 32'(bif.bus_addr), 32'h55);
    chkb("rd_rw",   bif.bus_rw, 1'b1);
    cyc();
    chkb("rd_as_n3", bif.bus_as_, 1'b1);
    chkd("rd_addr_w", 32'(bif.bus_addr), 32'h55);
    chkb("rd_ack_n3", bif.core_ack, 1'b0);
    bif.bus_rdy_ = 1'b0;
    cyc();
    bif.bus_rdy_ = 1'b1;
    chkb("rd_ack",  bif.core_ack, 1'b1);
    chkb("rd_err",  bif.core_err, 1'b0);
    chkd("rd_data", bif.core_rd_data, 32'hDEADBEEF);
    chkb("rd_rel",  bif.bus_req_, 1'b1);
    chkd("rd_rel_a", 32'(bif.bus_addr), 32'h0);
    cyc();
    chkb("rd_ack_n5", bif.core_ack, 1'b0);
    chkb("rd_idle_busy", bif.core_busy, 1'b0);

    // write, grant delayed
    bif.bus_grnt_   = 1'b1;
    bif.bus_rd_data = 32'hCAFEF00D;
    issue(1'b0, 30'h100, 32'h12345678);
    cyc();
    bif.core_req = 1'b0;
    chkb("wr_req_n1", bif.bus_req_, 1'b0);
    cyc();
    chkb("wr_req_n2", bif.bus_req_, 1'b0);
    chkb("wr_as_n2",  bif.bus_as_, 1'b1);
    cyc();
    chkb("wr_as_n3",  bif.bus_as_, 1'b1);
    bif.bus_grnt_ = 1'b0;
    cyc();
    chkb("wr_as",   bif.bus_as_, 1'b0);
    chkd("wr_addr", 32'(bif.bus_addr), 32'h100);
    chkd("wr_wd",   bif.bus_wr_data, 32'h12345678);
    chkb("wr_rw",   bif.bus_rw, 1'b0);
    cyc();
    chkb("wr_as_w", bif.bus_as_, 1'b1);
    chkd("wr_wd_w", bif.bus_wr_data, 32'h12345678);
    bif.bus_rdy_ = 1'b0;
    cyc();
    bif.bus_rdy_ = 1'b1;
    chkb("wr_ack",  bif.core_ack, 1'b1);
    chkb("wr_err",  bif.core_err, 1'b0);
    chkd("wr_rdat", bif.core_rd_data, 32'h0);
    chkd("wr_wd_rel", bif.bus_wr_data, 32'h0);
    chkb("wr_rw_rel", bif.bus_rw, 1'b1);
    cyc();

    // ready arrives on 4th WAIT cycle
    bif.bus_rd_data = 32'h0BADF00D;
    issue(1'b1, 30'h7, 32'h0);
    cyc();
    bif.core_req = 1'b0;
    cyc();
    for (int i = 0; i < 3; i++) begin
      cyc();
      chkb("tcr_noack", bif.core_ack, 1'b0);
    end
    cyc();
    chkb("tcr_noack4", bif.core_ack, 1'b0);
    bif.bus_rdy_ = 1'b0;
    cyc();
    bif.bus_rdy_ = 1'b1;
    chkb("tcr_ack",  bif.core_ack, 1'b1);
    chkb("tcr_err",  bif.core_err, 1'b0);
    chkd("tcr_data", bif.core_rd_data, 32'h0BADF00D);
    cyc();

    // grant lost during WAIT
    issue(1'b1, 30'h8, 32'h0);
    cyc();
    bif.core_req = 1'b0;
    cyc();
    cyc();
    bif.bus_grnt_ = 1'b1;
    cyc();
    bif.bus_grnt_ = 1'b0;
    chkb("gl_ack",  bif.core_ack, 1'b1);
    chkb("gl_err",  bif.core_err, 1'b1);
    chkd("gl_data", bif.core_rd_data, 32'h0);
    cyc();

    // watchdog timeout, ready never comes
    bif.bus_rd_data = 32'hAAAA5555;
    issue(1'b1, 30'h3, 32'h0);
    cyc();
    bif.core_req = 1'b0;
    cyc();
    for (int i = 0; i < 4; i++) begin
      cyc();
      chkb("to_noack", bif.core_ack, 1'b0);
      chkb("to_req",   bif.bus_req_, 1'b0);
    end
    cyc();
    chkb("to_ack",  bif.core_ack, 1'b1);
    chkb("to_err",  bif.core_err, 1'b1);
    chkd("to_data", bif.core_rd_data, 32'h0);
    chkb("to_rel",  bif.bus_req_, 1'b1);
    chkd("to_addr", 32'(bif.bus_addr), 32'h0);
    cyc();
    chkb("to_ack_off", bif.core_ack, 1'b0);

    // reset pulsed during WAIT
    issue(1'b1, 30'h9, 32'h0);
    cyc();
    bif.core_req = 1'b0;
    cyc();
    cyc();
    cyc();
    chkb("rs_pre_req", bif.bus_req_, 1'b0);
    chkd("rs_pre_addr", 32'(bif.bus_addr), 32'h9);
    reset = 1'b1;
    #1;
    chk_rst_vals("rs_async");
    cyc();
    chkb("rs_ack_hold", bif.core_ack, 1'b0);
    reset = 1'b0;
    cyc();
    chkb("rs_ack_after", bif.core_ack, 1'b0);
    chkb("rs_busy", bif.core_busy, 1'b0);
    bif.bus_rd_data = 32'h11223344;
    issue(1'b1, 30'hA, 32'h0);
    cyc();
    bif.core_req = 1'b0;
    cyc();
    chkd("rs_new_addr", 32'(bif.bus_addr), 32'hA);
    cyc();
    bif.bus_rdy_ = 1'b0;
    cyc();
    bif.bus_rdy_ = 1'b1;
    chkb("rs_new_ack",  bif.core_ack, 1'b1);
    chkb("rs_new_err",  bif.core_err, 1'b0);
    chkd("rs_new_data", bif.core_rd_data, 32'h11223344);
    cyc();

    // core_req held high: back-to-back
    acks = 0;
    bif.bus_rdy_    = 1'b0;
    bif.bus_rd_data = 32'h55AA55AA;
    issue(1'b1, 30'h20, 32'h0);
    cyc();
    bif.core_addr = 30'h21;
    chkb("bb_req1", bif.bus_req_, 1'b0);
    cyc();
    chkd("bb_addr1", 32'(bif.bus_addr), 32'h20);
    chkb("bb_as1", bif.bus_as_, 1'b0);
    cyc();
    cyc();
    chkb("bb_ack1", bif.core_ack, 1'b1);
    chkb("bb_done_req", bif.bus_req_, 1'b1);
    chkd("bb_data1", bif.core_rd_data, 32'h55AA55AA);
    cyc();
    chkb("bb_idle_req", bif.bus_req_, 1'b1);
    chkb("bb_idle_ack", bif.core_ack, 1'b0);
    chkb("bb_idle_busy", bif.core_busy, 1'b0);
    cyc();
    chkb("bb_req2", bif.bus_req_, 1'b0);
    chkb("bb_busy2", bif.core_busy, 1'b1);
    cyc();
    chkd("bb_addr2", 32'(bif.bus_addr), 32'h21);
    cyc();
    cyc();
    bif.core_req = 1'b0;
    bif.bus_rdy_ = 1'b1;
    chkb("bb_ack2", bif.core_ack, 1'b1);
    cyc();
    cyc();
    chkd("bb_ack_count", 32'(acks), 32'd2);
    chkb("bb_end_busy", bif.core_busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
